// File: rtl/handshake_const_pkg.sv
// Shared helpers for the handshake constant sequencer: index sizing and
// zero/sign extension of narrow table entries.
package handshake_const_pkg;

    // Widest output the extension helper supports.
    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] wide_t;

    // Index width with a floor of one bit, so NUM_CONSTS = 1 still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Extends the low 'width' bits of value to MAX_WIDTH.
    // Bits at and above 'width' are replaced by the sign bit or by zeros.
    function automatic wide_t const_ext(input wide_t value, input int width,
                                        input bit sign_ext);
        wide_t r;
        logic  msb;
        r   = '0;
        msb = value[width-1];
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) r[i] = value[i];
            else           r[i] = sign_ext & msb;
        end
        return r;
    endfunction

endpackage

// File: rtl/handshake_oehb_slot.sv
// One-slot opaque elastic buffer: registers data and valid and refills in the
// same cycle the held token is consumed, which keeps full throughput.
module handshake_oehb_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    // Handshake: a token moves across an interface on a rising clk edge where
    // valid && ready are both 1; valid never depends on ready, and a valid
    // token with its data is held unchanged until it is taken.
    assign ins_ready = !outs_valid || outs_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs       <= '0;
            outs_valid <= 1'b0;
        end else if (ins_valid && ins_ready) begin
            outs       <= ins;
            outs_valid <= 1'b1;
        end else if (outs_ready) begin
            // Consumed with nothing to replace it: data keeps its last value.
            outs_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// Constant source that emits the next entry of a compile-time table for each
// control token, through a one-slot registered output (DATA_WIDTH <= 64).
module handshake_constant_seq
    import handshake_const_pkg::*;
#(
    parameter int                                 DATA_WIDTH  = 32,
    parameter int                                 CONST_WIDTH = 12,
    parameter int                                 NUM_CONSTS  = 4,
    parameter logic [NUM_CONSTS*CONST_WIDTH-1:0]  CONST_TABLE = '0,
    parameter bit                                 SIGN_EXT    = 1'b0,
    parameter bit                                 WRAP        = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ctrl_valid,
    output logic                                 ctrl_ready,
    input  logic                                 seq_restart,
    output logic [DATA_WIDTH-1:0]                outs,
    output logic                                 outs_valid,
    input  logic                                 outs_ready,
    output logic [idx_width(NUM_CONSTS)-1:0]     outs_idx
);

    localparam int              IW       = idx_width(NUM_CONSTS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_CONSTS - 1);

    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_eff;
    logic [IW-1:0]          idx_next;
    logic [CONST_WIDTH-1:0] entry;
    logic [DATA_WIDTH-1:0]  entry_ext;
    logic                   accept;
    logic [IW-1:0]          slot_idx;
    logic [DATA_WIDTH-1:0]  slot_data;

    assign accept  = ctrl_valid && ctrl_ready;
    // A restart applies to the token accepted in the same cycle.
    assign idx_eff = seq_restart ? '0 : idx_q;

    always_comb begin
        idx_next = idx_eff + 1'b1;
        if (idx_eff == LAST_IDX) begin
            idx_next = WRAP ? '0 : LAST_IDX;
        end
    end

    assign entry     = CONST_TABLE[int'(idx_eff)*CONST_WIDTH +: CONST_WIDTH];
    assign entry_ext = DATA_WIDTH'(const_ext(wide_t'(entry), CONST_WIDTH, SIGN_EXT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= idx_next;
        end else if (seq_restart) begin
            idx_q <= '0;
        end
    end

    // The index rides alongside the data so outs_idx always names the held token.
    handshake_oehb_slot #(
        .DATA_WIDTH (DATA_WIDTH + IW)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .ins        ({idx_eff, entry_ext}),
        .ins_valid  (ctrl_valid),
        .ins_ready  (ctrl_ready),
        .outs       ({slot_idx, slot_data}),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    assign outs     = slot_data;
    assign outs_idx = slot_idx;

endmodule
